bus_arbiter: RTL and testbench

//  Shares one single-port Wishbone-style bus between the IF stage (instruction fetch) and the MEM stage (load/store).

---
 rtl/bus_arbiter_pkg.sv | 17 +
 rtl/bus_timeout_cnt.sv | 35 +++
 rtl/bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM bus arbiter.
//   arb_state_e : arbiter FSM state encoding (2 bits)
//   ZeroWord    : all-zero 32-bit word used for cleared data paths
//   TimeoutW    : width of the bus timeout counter
package bus_arbiter_pkg;

  localparam int unsigned TimeoutW = 8;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIf    = 2'd1,
    StMem   = 2'd2,
    StDrain = 2'd3
  } arb_state_e;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Bus access watchdog. Counts cycles while an access is outstanding and flags
// expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
//   clk, rst   : clock, synchronous active-high reset
//   clear_i    : zero the count (takes priority over enable_i)
//   enable_i   : count this cycle
//   expire_o   : access has been outstanding for TIMEOUT_CYCLES cycles
module bus_timeout_cnt
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [TimeoutW-1:0] ExpireAt = TimeoutW'(TIMEOUT_CYCLES - 1);

  logic [TimeoutW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + TimeoutW'(1);
    end
  end

  assign expire_o = enable_i && (cnt_q == ExpireAt);

endmodule

// File: rtl/bus_arbiter.sv
// Shares one single-port Wishbone-style bus between instruction fetch (IF) and
// load/store (MEM). MEM has fixed priority; an access is never preempted.
//   clk, rst                     : clock, synchronous active-high reset
//   if_req_i/if_addr_i           : fetch request, held until if_ack_o
//   if_rdata_o/if_ack_o          : fetched word and one-cycle completion pulse
//   flush_i                      : cancels the outstanding fetch (data discarded)
//   mem_req_i/we/sel/addr/wdata  : load/store request, held until mem_ack_o
//   mem_rdata_o/mem_ack_o        : load data (0 for stores) and completion pulse
//   err_o                        : qualifies the same-cycle ack as a timeout
//   stall_if_o/stall_mem_o       : per-stage stall requests
//   bus_*                        : registered bus master signals, bus_rdata_i/bus_ack_i slave side
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        flush_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        err_o,
  output logic        stall_if_o,
  output logic        stall_mem_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  arb_state_e  state_q;
  logic        cyc_q, we_q, if_ack_q, mem_ack_q, err_q;
  logic [3:0]  sel_q;
  logic [31:0] addr_q, wdata_q, if_rdata_q, mem_rdata_q;
  logic        expire;
  logic        mem_go, if_go;

  bus_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q == StIdle),
    .enable_i (state_q != StIdle),
    .expire_o (expire)
  );

  // A requester being acked this cycle still holds req; ignore it so the same
  // access is not issued twice.
  assign mem_go = mem_req_i && !mem_ack_q;
  assign if_go  = if_req_i && !if_ack_q && !flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      addr_q      <= ZeroWord;
      wdata_q     <= ZeroWord;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= ZeroWord;
      mem_rdata_q <= ZeroWord;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      err_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mem_go) begin
            state_q <= StMem;
            cyc_q   <= 1'b1;
            we_q    <= mem_we_i;
            sel_q   <= mem_sel_i;
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
          end else if (if_go) begin
            state_q <= StIf;
            cyc_q   <= 1'b1;
            we_q    <= 1'b0;
            sel_q   <= 4'hF;
            addr_q  <= if_addr_i;
            wdata_q <= ZeroWord;
          end
        end
        StIf: begin
          if (flush_i) begin
            // Cancelled fetch: the slave must still finish the cycle.
            if (bus_ack_i || expire) begin
              state_q <= StIdle;
              cyc_q   <= 1'b0;
            end else begin
              state_q <= StDrain;
            end
          end else if (bus_ack_i) begin
            state_q    <= StIdle;
            cyc_q      <= 1'b0;
            if_ack_q   <= 1'b1;
            if_rdata_q <= bus_rdata_i;
          end else if (expire) begin
            state_q    <= StIdle;
            cyc_q      <= 1'b0;
            if_ack_q   <= 1'b1;
            err_q      <= 1'b1;
            if_rdata_q <= ZeroWord;
          end
        end
        StMem: begin
          if (bus_ack_i) begin
            state_q     <= StIdle;
            cyc_q       <= 1'b0;
            mem_ack_q   <= 1'b1;
            mem_rdata_q <= we_q ? ZeroWord : bus_rdata_i;
          end else if (expire) begin
            state_q     <= StIdle;
            cyc_q       <= 1'b0;
            mem_ack_q   <= 1'b1;
            err_q       <= 1'b1;
            mem_rdata_q <= ZeroWord;
          end
        end
        StDrain: begin
          if (bus_ack_i || expire) begin
            state_q <= StIdle;
            cyc_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_cyc_o   = cyc_q;
  assign bus_stb_o   = cyc_q;
  assign bus_we_o    = we_q;
  assign bus_sel_o   = sel_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign if_ack_o    = if_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_ack_o   = mem_ack_q;
  assign mem_rdata_o = mem_rdata_q;
  assign err_o       = err_q;
  assign stall_if_o  = if_req_i && !if_ack_q;
  assign stall_mem_o = mem_req_i && !mem_ack_q;

  // Requests must be held until acked (a flushed fetch may drop its request).
  a_mem_req_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == StMem) |-> mem_req_i);
  a_if_req_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == StIf && !flush_i) |-> if_req_i);

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, flush_i, mem_req_i, mem_we_i, bus_ack_i;
  logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i, bus_rdata_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] if_rdata_o, mem_rdata_o, bus_addr_o, bus_wdata_o;
  logic        if_ack_o, mem_ack_o, err_o, stall_if_o, stall_mem_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [3:0]  bus_sel_o;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_ack_o    (if_ack_o),
    .flush_i     (flush_i),
    .mem_req_i   (mem_req_i),
    .mem_we_i    (mem_we_i),
    .mem_sel_i   (mem_sel_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_rdata_o (mem_rdata_o),
    .mem_ack_o   (mem_ack_o),
    .err_o       (err_o),
    .stall_if_o  (stall_if_o),
    .stall_mem_o (stall_mem_o),
    .bus_cyc_o   (bus_cyc_o),
    .bus_stb_o   (bus_stb_o),
    .bus_we_o    (bus_we_o),
    .bus_sel_o   (bus_sel_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ack_i   (bus_ack_i)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req_v);
    checks++;
    assert (obs === req_v)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, req_v);
    end
  endtask

  initial begin
    rst = 1'b1;
    if_req_i = 1'b0; flush_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
    bus_ack_i = 1'b0; if_addr_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
    bus_rdata_i = '0; mem_sel_i = '0;
    tick(); tick();
    chk("rst_cyc", {31'd0, bus_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, bus_stb_o}, 32'd0);
    chk("rst_addr", bus_addr_o, 32'd0);
    chk("rst_acks", {29'd0, if_ack_o, mem_ack_o, err_o}, 32'd0);
    rst = 1'b0;
    tick();

    // 1. Lone IF read, slave acks 2 cycles after strobe.
    if_req_i = 1'b1; if_addr_i = 32'h4;
    #1 chk("t1_stall_if_req", {31'd0, stall_if_o}, 32'd1);
    tick();
    chk("t1_stb", {31'd0, bus_stb_o}, 32'd1);
    chk("t1_addr", bus_addr_o, 32'h4);
    chk("t1_we", {31'd0, bus_we_o}, 32'd0);
    tick();
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h3401_1100;
    chk("t1_no_early_ack", {31'd0, if_ack_o}, 32'd0);
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    chk("t1_ack", {31'd0, if_ack_o}, 32'd1);
    chk("t1_rdata", if_rdata_o, 32'h3401_1100);
    chk("t1_err", {31'd0, err_o}, 32'd0);
    chk("t1_cyc_drop", {31'd0, bus_cyc_o}, 32'd0);
    #1 chk("t1_stall_if_ack", {31'd0, stall_if_o}, 32'd0);

    // 6. Back-to-back IF: new address the cycle after the ack.
    tick();
    chk("t6_no_dup", {31'd0, bus_cyc_o}, 32'd0);
    chk("t6_ack_gone", {31'd0, if_ack_o}, 32'd0);
    if_addr_i = 32'h8;
    tick();
    chk("t6_stb", {31'd0, bus_stb_o}, 32'd1);
    chk("t6_addr", bus_addr_o, 32'h8);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0013;
    tick();
    bus_ack_i = 1'b0;
    chk("t6_ack", {31'd0, if_ack_o}, 32'd1);
    chk("t6_rdata", if_rdata_o, 32'h0000_0013);
    if_req_i = 1'b0;
    tick();

    // 2. Simultaneous IF fetch and MEM store: MEM first.
    if_req_i = 1'b1; if_addr_i = 32'hC;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h100;
    mem_wdata_i = 32'hDEAD_BEEF; mem_sel_i = 4'b1111;
    #1 chk("t2_stall_mem_req", {31'd0, stall_mem_o}, 32'd1);
    tick();
    chk("t2_addr", bus_addr_o, 32'h100);
    chk("t2_we", {31'd0, bus_we_o}, 32'd1);
    chk("t2_wdata", bus_wdata_o, 32'hDEAD_BEEF);
    chk("t2_sel", {28'd0, bus_sel_o}, 32'hF);
    chk("t2_stall_if_a", {31'd0, stall_if_o}, 32'd1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0055;
    tick();
    bus_ack_i = 1'b0;
    chk("t2_mem_ack", {31'd0, mem_ack_o}, 32'd1);
    chk("t2_store_rdata", mem_rdata_o, 32'h0);
    chk("t2_if_ack_excl", {31'd0, if_ack_o}, 32'd0);
    chk("t2_stall_if_b", {31'd0, stall_if_o}, 32'd1);
    chk("t2_stall_mem_ack", {31'd0, stall_mem_o}, 32'd0);
    mem_req_i = 1'b0;
    tick();
    chk("t2_if_stb", {31'd0, bus_stb_o}, 32'd1);
    chk("t2_if_addr", bus_addr_o, 32'hC);
    chk("t2_if_we", {31'd0, bus_we_o}, 32'd0);
    chk("t2_stall_if_c", {31'd0, stall_if_o}, 32'd1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hA5A5_0001;
    tick();
    bus_ack_i = 1'b0;
    chk("t2_if_ack", {31'd0, if_ack_o}, 32'd1);
    chk("t2_if_rdata", if_rdata_o, 32'hA5A5_0001);
    if_req_i = 1'b0;
    tick();

    // 3. Flush the cycle after the IF grant; queued MEM load follows.
    if_req_i = 1'b1; if_addr_i = 32'h20;
    tick();
    chk("t3_stb", {31'd0, bus_stb_o}, 32'd1);
    flush_i = 1'b1;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h200; mem_sel_i = 4'b0011;
    mem_wdata_i = 32'h0;
    #1 chk("t3_stall_mem", {31'd0, stall_mem_o}, 32'd1);
    tick();
    flush_i = 1'b0; if_req_i = 1'b0;
    chk("t3_drain_cyc", {31'd0, bus_cyc_o}, 32'd1);
    chk("t3_drain_addr", bus_addr_o, 32'h20);
    tick();
    chk("t3_drain_cyc2", {31'd0, bus_cyc_o}, 32'd1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0BAD;
    tick();
    bus_ack_i = 1'b0;
    chk("t3_cyc_drop", {31'd0, bus_cyc_o}, 32'd0);
    chk("t3_no_if_ack", {31'd0, if_ack_o}, 32'd0);
    chk("t3_no_mem_ack", {31'd0, mem_ack_o}, 32'd0);
    tick();
    chk("t3_mem_addr", bus_addr_o, 32'h200);
    chk("t3_mem_sel", {28'd0, bus_sel_o}, 32'h3);
    chk("t3_mem_stb", {31'd0, bus_stb_o}, 32'd1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1234_5678;
    tick();
    bus_ack_i = 1'b0;
    chk("t3_mem_ack", {31'd0, mem_ack_o}, 32'd1);
    chk("t3_mem_rdata", mem_rdata_o, 32'h1234_5678);
    chk("t3_no_if_ack2", {31'd0, if_ack_o}, 32'd0);
    mem_req_i = 1'b0;
    tick();

    // 4. Timeout on a MEM load (TIMEOUT_CYCLES = 8).
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h300; mem_sel_i = 4'hF;
    bus_rdata_i = 32'hFFFF_FFFF;
    tick();
    chk("t4_stb", {31'd0, bus_stb_o}, 32'd1);
    repeat (7) tick();
    chk("t4_cyc_8th", {31'd0, bus_cyc_o}, 32'd1);
    chk("t4_no_ack_yet", {31'd0, mem_ack_o}, 32'd0);
    tick();
    chk("t4_cyc_drop", {31'd0, bus_cyc_o}, 32'd0);
    chk("t4_ack", {31'd0, mem_ack_o}, 32'd1);
    chk("t4_err", {31'd0, err_o}, 32'd1);
    chk("t4_rdata", mem_rdata_o, 32'h0);
    mem_req_i = 1'b0;
    tick();
    chk("t4_err_pulse", {31'd0, err_o}, 32'd0);

    // 4b. bus_ack_i in the expiry cycle wins over the timeout.
    mem_req_i = 1'b1; mem_addr_i = 32'h304;
    tick();
    repeat (7) tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0BAD_F00D;
    tick();
    bus_ack_i = 1'b0;
    chk("t4b_ack", {31'd0, mem_ack_o}, 32'd1);
    chk("t4b_err", {31'd0, err_o}, 32'd0);
    chk("t4b_rdata", mem_rdata_o, 32'h0BAD_F00D);
    mem_req_i = 1'b0;
    tick();

    // 5. Reset during a MEM store, then a normal IF fetch.
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h400;
    mem_wdata_i = 32'h11; mem_sel_i = 4'b0001;
    tick();
    chk("t5_cyc", {31'd0, bus_cyc_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_req_i = 1'b0;
    chk("t5_rst_cyc", {31'd0, bus_cyc_o}, 32'd0);
    chk("t5_rst_bus", {bus_addr_o[27:0], bus_sel_o}, 32'd0);
    chk("t5_rst_wdata", bus_wdata_o, 32'd0);
    chk("t5_rst_we_acks", {28'd0, bus_we_o, if_ack_o, mem_ack_o, err_o}, 32'd0);
    tick();
    chk("t5_no_ack", {31'd0, mem_ack_o}, 32'd0);
    chk("t5_idle", {31'd0, bus_cyc_o}, 32'd0);
    if_req_i = 1'b1; if_addr_i = 32'h40;
    tick();
    chk("t5_if_addr", bus_addr_o, 32'h40);
    chk("t5_if_stb", {31'd0, bus_stb_o}, 32'd1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0077;
    tick();
    bus_ack_i = 1'b0;
    chk("t5_if_ack", {31'd0, if_ack_o}, 32'd1);
    chk("t5_if_rdata", if_rdata_o, 32'h0000_0077);
    if_req_i = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
